// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default line settings and
// the baud divisor helper used by both the receiver and the transmitter.
package uart_pkg;

    localparam int unsigned DEFAULT_CLK_FREQ  = 27000000;
    localparam int unsigned DEFAULT_BAUD_RATE = 9600;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Clocks per bit period (integer division, remainder dropped).
    function automatic int unsigned bit_div(input int unsigned clk_hz,
                                            input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit. RESET_VAL sets
// the value both flops take while reset is asserted.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Shift the asynchronous input through two flops to settle metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            // NOTE: non-blocking assignments make both flops sample together,
            // giving a true two-stage pipeline instead of one collapsed flop.
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, mid-bit sampling from a clock-derived
// baud counter. Define UART_RX_PARITY_EN to add an even-parity bit after
// bit 7 and the parity_err output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = DEFAULT_CLK_FREQ,
    parameter int unsigned BAUD_RATE = DEFAULT_BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int unsigned BIT_DIV  = bit_div(CLK_FREQ, BAUD_RATE);
    localparam int unsigned HALF_DIV = BIT_DIV / 2;
    localparam int          CNT_W    = $clog2(BIT_DIV);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);

    logic             w_rx_s;
    rx_state_t        r_state;
    rx_state_t        w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_frame_err;
    logic             r_armed;
    logic             w_tick;
    logic             w_sample_data;
    logic             w_stop_done;
    logic             w_frame_ok;
    logic             w_frame_bad;
`ifdef UART_RX_PARITY_EN
    logic             w_sample_parity;
    logic             r_par_acc;
    logic             r_par_bad;
    logic             r_parity_err;
`endif

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rx_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and per-cycle sample strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        w_state_next  = r_state;
        w_tick        = 1'b0;
        w_sample_data = 1'b0;
        w_stop_done   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_sample_parity = 1'b0;
`endif
        case (r_state)
            RX_IDLE: begin
                if (r_armed && !w_rx_s) begin
                    w_state_next = RX_START;
                end
            end
            RX_START: begin
                if (r_cnt == HALF_LAST) begin
                    w_tick       = 1'b1;
                    // A line back high at mid start bit was only a glitch.
                    w_state_next = w_rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_cnt == BIT_LAST) begin
                    w_tick        = 1'b1;
                    w_sample_data = 1'b1;
                    if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = RX_PARITY;
`else
                        w_state_next = RX_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (r_cnt == BIT_LAST) begin
                    w_tick          = 1'b1;
                    w_sample_parity = 1'b1;
                    w_state_next    = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (r_cnt == BIT_LAST) begin
                    w_tick       = 1'b1;
                    w_stop_done  = 1'b1;
                    w_state_next = RX_IDLE;
                end
            end
            default: begin
                w_state_next = RX_IDLE;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign w_frame_ok = w_stop_done && w_rx_s && !r_par_bad;
`else
    assign w_frame_ok = w_stop_done && w_rx_s;
`endif
    assign w_frame_bad = w_stop_done && !w_frame_ok;

    // Baud counter: held at zero in IDLE, restarts on every sample point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == RX_IDLE || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Shift register, output byte, strobes and start-edge arming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx       <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_valid     <= w_frame_ok;
            r_frame_err <= w_frame_bad;
            if (w_frame_ok) begin
                r_data <= r_shift;
            end
            if (r_state == RX_IDLE) begin
                r_idx <= 3'd0;
            end else if (w_sample_data) begin
                r_shift[r_idx] <= w_rx_s;
                r_idx          <= r_idx + 3'd1;
            end
            // A low stop bit disarms edge detection until the line idles
            // high, so a held break yields one frame_err. A high stop bit
            // keeps it armed for a back-to-back start.
            if (w_stop_done) begin
                r_armed <= w_rx_s;
            end else if (r_state == RX_IDLE && w_rx_s) begin
                r_armed <= 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even-parity accumulation over data bits and check against parity bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_acc    <= 1'b0;
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_frame_bad && r_par_bad;
            if (r_state == RX_IDLE) begin
                r_par_acc <= 1'b0;
                r_par_bad <= 1'b0;
            end else begin
                if (w_sample_data) begin
                    r_par_acc <= r_par_acc ^ w_rx_s;
                end
                if (w_sample_parity) begin
                    r_par_bad <= r_par_acc ^ w_rx_s;
                end
            end
        end
    end

    assign parity_err = r_parity_err;
`endif

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLK_FREQ=160, BAUD_RATE=10 (16 clocks
// per bit). Frames are driven on the falling clock edge; each driven frame
// pushes its expected byte, status and arrival cycle to a scoreboard that a
// monitor pops whenever valid or frame_err fires.
module tb_uart_rx;

    localparam int unsigned BIT = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 2 + 8 + 10 * 16 + 1;
`else
    localparam int LAT = 2 + 8 + 9 * 16 + 1;
`endif

    typedef struct {
        logic [7:0] data;
        bit         err;
        bit         perr;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] last_good;
    int         cyc;
    int         n_total;
    int         n_bad;

    uart_rx #(
        .CLK_FREQ  (160),
        .BAUD_RATE (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one frame starting at a falling edge; returns at a falling edge.
    task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit par_ok);
        exp_t e;
        bit   err;
        bit   perr;
        err  = !stop_bit;
        perr = 1'b0;
`ifdef UART_RX_PARITY_EN
        if (!par_ok) begin
            err  = 1'b1;
            perr = 1'b1;
        end
`else
        perr = perr & par_ok;
`endif
        e.data = err ? last_good : b;
        e.err  = err;
        e.perr = perr;
        e.cyc  = cyc + LAT;
        if (!err) last_good = b;
        sb.push_back(e);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_ok ? ^b : ~^b;
        repeat (BIT) @(negedge clk);
`endif
        rx = stop_bit;
        repeat (BIT) @(negedge clk);
    endtask

    // Monitor: every output strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (valid || frame_err)) begin
            check("sb_has_entry", sb.size() != 0, 1);
            check("valid_frame_err_exclusive", valid & frame_err, 0);
            check("busy_low_at_strobe", busy, 0);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("data", data, mon_e.data);
                check("valid", valid, !mon_e.err);
                check("frame_err", frame_err, mon_e.err);
`ifdef UART_RX_PARITY_EN
                check("parity_err", parity_err, mon_e.perr);
`endif
                check("strobe_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        int c0;
        n_total   = 0;
        n_bad     = 0;
        last_good = 8'h00;
        rx        = 1'b1;
        rst       = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single frame, then back-to-back frames with no idle gap
        send_frame(8'hA5, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        repeat (20) @(negedge clk);

        // Four-clock glitch on idle line: false start, no strobe
        c0 = cyc;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy_high", busy, 1);
        rx = 1'b1;
        repeat (7) @(negedge clk);
        check("glitch_elapsed", cyc - c0, 11);
        check("glitch_busy_low", busy, 0);
        repeat (200) @(negedge clk);

        // Low stop bit followed by a 40-bit-time break: exactly one frame_err
        send_frame(8'h3C, 1'b0, 1'b1);
        repeat (40 * BIT) @(negedge clk);
        check("break_sb_drained", sb.size(), 0);
        check("break_data_held", data, 8'hFF);
        rx = 1'b1;
        repeat (40) @(negedge clk);

        // Reset during bit 4 aborts the frame
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            repeat (BIT) @(negedge clk);
        end
        rx = 1'b1;
        repeat (8) @(negedge clk);
        check("midframe_busy", busy, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_data", data, 8'h00);
        check("abort_valid", valid, 0);
        check("abort_frame_err", frame_err, 0);
        check("abort_busy", busy, 0);
`ifdef UART_RX_PARITY_EN
        check("abort_parity_err", parity_err, 0);
`endif
        rst       = 1'b0;
        last_good = 8'h00;
        repeat (20) @(negedge clk);
        send_frame(8'h5A, 1'b1, 1'b1);
        repeat (20) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        // Wrong parity, then correct parity
        send_frame(8'h07, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
`endif

        for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
        check("sb_empty_at_end", sb.size(), 0);
        check("final_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the board's UART link, 8N1 by default, LSB first. Counterpart of the serial transmitter: samples `rx` at mid-bit using a clock-derived baud counter and presents each received byte on a parallel port with a one-cycle valid strobe. Sits between the pin-level RX input and downstream byte consumers (command parser, loopback logic).

## Interface
- `CLK_FREQ`, 27000000, system clock frequency in Hz
- `BAUD_RATE`, 9600, line rate in bit/s
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `rx`  in  1  serial line, idle high, asynchronous to `clk`
- `data`  out  8  last received byte; held until the next valid frame
- `valid`  out  1  one-cycle pulse when `data` updates
- `frame_err`  out  1  one-cycle pulse when the stop bit samples low
- `busy`  out  1  high from start-edge detect until frame end

## Operation
- `BIT_DIV = CLK_FREQ / BAUD_RATE` (integer division; 2812 at defaults). `HALF_DIV = BIT_DIV / 2` (1406).
- `rx` passes through a 2-FF synchronizer (reset value 1). All decisions use the synchronized signal `rx_s`.
- FSM states and transitions:
  - IDLE: on `rx_s` 1→0, go to START and load the counter.
  - START: after HALF_DIV clocks, sample `rx_s`. If low, go to DATA with bit index 0. If high, it is a false start: return to IDLE with no output.
  - DATA: every BIT_DIV clocks, sample into shift register bit[index], LSB first. After index 7, go to STOP (or PARITY when configured).
  - STOP: after BIT_DIV clocks, sample `rx_s`. If high, update `data` and pulse `valid`. If low, pulse `frame_err`, leave `data` unchanged and do not pulse `valid`. Go to IDLE.
- After a low stop sample, IDLE waits for `rx_s` high before arming edge detection again. A held-low break line therefore produces exactly one `frame_err`.
- Counter width is `$clog2(BIT_DIV)`. The counter resets to 0 on each state entry.

## Timing
- Reset values: `data`=0x00, `valid`=0, `frame_err`=0, `busy`=0, FSM in IDLE, synchronizer=1.
- `rst` asserted mid-frame aborts immediately. No `valid` or `frame_err` is produced for the aborted frame.
- Synchronizer latency: 2 clocks.
- `valid` or `frame_err` asserts 1 clock after the stop-bit sample. That is 2 + HALF_DIV + 9·BIT_DIV + 1 clocks after the `rx` falling edge (10·BIT_DIV with parity).
- `busy` drops in the same cycle that `valid`/`frame_err` asserts.
- `valid` and `frame_err` are mutually exclusive in any cycle.
- Back-to-back frames with no idle gap are accepted: the next start edge is detected at the end of the stop bit.

## Configuration
- `UART_RX_PARITY_EN` defined: an even-parity bit follows bit 7, sampled in a PARITY state one BIT_DIV after bit 7. A parity mismatch pulses `frame_err` at frame end instead of `valid`. Adds output `parity_err` (1 bit, reset 0), pulsed together with `frame_err` for parity failures only.
- Undefined: 8N1, no PARITY state, no `parity_err` port.

## Structure
- Shared package `uart_pkg`: FSM state enum (`RX_IDLE`, `RX_START`, `RX_DATA`, `RX_PARITY`, `RX_STOP`), default `CLK_FREQ`/`BAUD_RATE` constants, and a `bit_div(clk, baud)` function reused by the transmitter.
- One sub-module, `uart_sync2`: 2-FF synchronizer with a reset value parameter.

## Test plan
Bench parameters: `CLK_FREQ`=160, `BAUD_RATE`=10 (BIT_DIV=16, HALF_DIV=8).

- Drive byte 0xA5 as 8N1 (LSB first, stop high) → `data`=0xA5, one `valid` pulse exactly 2+8+144+1=155 clocks after the start edge, `frame_err`=0.
- Drive 0x00 then 0xFF back-to-back with no idle gap → two `valid` pulses 160 clocks apart, carrying 0x00 then 0xFF.
- Drive a 4-clock low glitch on idle `rx` → no `valid`, no `frame_err`, `busy` returns to 0 within 11 clocks.
- Drive 0x3C with the stop bit low, then hold `rx` low for 40 bit times → one `frame_err` pulse, no `valid`, `data` keeps its previous value.
- Assert `rst` during bit 4 of a frame, release, then send 0x5A → all outputs at reset values during reset; next `valid` carries 0x5A.
- With `UART_RX_PARITY_EN`: send 0x07 with parity bit 0 (wrong) → `frame_err`=1 and `parity_err`=1 for one cycle, no `valid`. Send 0x07 with parity 1 → `valid`, `data`=0x07.
